// File: rtl/checker_mpu_fetch.sv
// Purpose : instruction fetch unit; drives a PC to instruction memory and queues fetched words in a 2-entry FIFO.
// Latency : start/jmp edge -> ins_valid_o high 2 cycles later; then one instruction per cycle.
// Backpress: issue credit counts FIFO occupancy plus the in-flight read, so ins_ready_i low stalls the PC with no loss.
//
// Ports:
//   sys_clk, sys_rst_n       clock, synchronous active-low reset
//   start/start_addr         enter RUN (or redirect when already running) at start_addr
//   stop                     abandon fetch, flush, return to IDLE (PC held)
//   jmp/jmp_addr             redirect in RUN; ignored in IDLE
//   mpu_addr/mpu_do          memory read address (== PC) / read data one cycle later
//   ins_o/ins_addr_o         FIFO head instruction and its address
//   ins_valid_o/ins_ready_i  head handshake
//   busy_o                   high while in RUN
module checker_mpu_fetch (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic        stop,
    input  logic        jmp,
    input  logic [15:0] jmp_addr,
    output logic [15:0] mpu_addr,
    input  logic [47:0] mpu_do,
    output logic [47:0] ins_o,
    output logic [15:0] ins_addr_o,
    output logic        ins_valid_o,
    input  logic        ins_ready_i,
    output logic        busy_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        infl_q, infl_d;
    logic [15:0] infl_addr_q, infl_addr_d;

    // 2-entry FIFO: head pointer plus occupancy; tail is derived.
    logic        head_q, head_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [47:0] dat_q [2];
    logic [47:0] dat_d [2];
    logic [15:0] fadr_q [2];
    logic [15:0] fadr_d [2];

    logic        pop;
    logic        jmp_hit;
    logic        tail;
    logic [2:0]  credit;

    assign ins_valid_o = (cnt_q != 2'd0);
    assign ins_o       = dat_q[head_q];
    assign ins_addr_o  = fadr_q[head_q];
    assign mpu_addr    = pc_q;
    assign busy_o      = (state_q == ST_RUN);

    assign pop     = ins_valid_o & ins_ready_i;
    assign jmp_hit = jmp & (state_q == ST_RUN);
    // With cnt_q == 2 the tail aliases the head; that slot is only written
    // when the head is popped in the same cycle, so nothing is overwritten early.
    assign tail    = head_q ^ cnt_q[0];
    // Occupancy the FIFO will have after this cycle's pop, counting the
    // read already in flight; issuing only below 2 guarantees a free slot.
    assign credit  = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        infl_d      = 1'b0;
        infl_addr_d = infl_addr_q;
        head_d      = head_q;
        cnt_d       = cnt_q;
        dat_d       = dat_q;
        fadr_d      = fadr_q;

        if (stop) begin
            // PC held; any in-flight read is dropped by leaving infl_d low.
            state_d = ST_IDLE;
            head_d  = 1'b0;
            cnt_d   = 2'd0;
        end else if (start) begin
            state_d = ST_RUN;
            pc_d    = start_addr;
            head_d  = 1'b0;
            cnt_d   = 2'd0;
        end else if (jmp_hit) begin
            pc_d    = jmp_addr;
            head_d  = 1'b0;
            cnt_d   = 2'd0;
        end else begin
            if (infl_q) begin
                dat_d[tail]  = mpu_do;
                fadr_d[tail] = infl_addr_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};

            if ((state_q == ST_RUN) && (credit < 3'd2)) begin
                pc_d        = pc_q + 16'd1;
                infl_d      = 1'b1;
                infl_addr_d = pc_q;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= 16'h0000;
            infl_q      <= 1'b0;
            infl_addr_q <= 16'h0000;
            head_q      <= 1'b0;
            cnt_q       <= 2'd0;
            dat_q[0]    <= 48'h0;
            dat_q[1]    <= 48'h0;
            fadr_q[0]   <= 16'h0;
            fadr_q[1]   <= 16'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            infl_q      <= infl_d;
            infl_addr_q <= infl_addr_d;
            head_q      <= head_d;
            cnt_q       <= cnt_d;
            dat_q       <= dat_d;
            fadr_q      <= fadr_d;
        end
    end

endmodule

// File: doc/checker_mpu_fetch.md
CHECKER_MPU_FETCH -- requirements
Module: checker_mpu_fetch

Interface
REQ-001 SHALL have parameter none; all widths fixed (address 16, instruction 48).
REQ-002 sys_clk  in  1  single clock; all state updates on rising edge.
REQ-003 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  pulse: load PC from start_addr, enter RUN.
REQ-005 start_addr  in  16  first fetch address.
REQ-006 stop  in  1  pulse: abandon fetch, flush, enter IDLE.
REQ-007 jmp  in  1  pulse: redirect PC to jmp_addr, flush (RUN only).
REQ-008 jmp_addr  in  16  redirect target.
REQ-009 mpu_addr  out  16  read address to instruction memory.
REQ-010 mpu_do  in  48  memory read data; valid the cycle after its address is sampled.
REQ-011 ins_o  out  48  instruction at FIFO head.
REQ-012 ins_addr_o  out  16  address of ins_o.
REQ-013 ins_valid_o  out  1  FIFO head valid.
REQ-014 ins_ready_i  in  1  consumer accepts head when high with ins_valid_o.
REQ-015 busy_o  out  1  high in RUN.

Function
REQ-016 States: IDLE, RUN; IDLE->RUN on start; RUN->IDLE on stop; start in RUN behaves as jmp to start_addr.
REQ-017 Priority per cycle: stop > start > jmp > normal fetch.
REQ-018 mpu_addr SHALL equal the PC register at all times.
REQ-019 Issue: in RUN, fetch of PC issued in cycle when (fifo_count + inflight - pop) < 2 and no stop/start/jmp that cycle; PC <= PC+1 on issue, inflight <= 1.
REQ-020 PC increment wraps 16'hFFFF -> 16'h0000 with no error.
REQ-021 Capture: cycle after an issue, mpu_do and its address written into a 2-entry FIFO unless squashed; inflight cleared.
REQ-022 Pop: head removed when ins_valid_o & ins_ready_i; push and pop in same cycle on full or one-entry FIFO SHALL both succeed, count unchanged.
REQ-023 FIFO full (2) with no pop: no issue; no data lost, since issue credit counts inflight.
REQ-024 Steady state with ins_ready_i high: one instruction per cycle after 2-cycle initial latency (start edge -> ins_valid_o high 2 cycles later).
REQ-025 jmp/start in RUN: FIFO cleared, in-flight fetch squashed (its data not captured), PC <= target; first issue of target the following cycle; ins_valid_o low the cycle after redirect.
REQ-026 stop: FIFO cleared, inflight squashed, ins_valid_o low next cycle, PC held.
REQ-027 jmp in IDLE SHALL be ignored; ins_ready_i while ins_valid_o low SHALL be ignored.
REQ-028 ins_o/ins_addr_o SHALL be stable while ins_valid_o high and ins_ready_i low.
REQ-029 busy_o SHALL be registered state decode (high exactly in RUN).

Reset
REQ-030 sys_rst_n low at a clock edge SHALL force: state IDLE, PC/mpu_addr 16'h0000, FIFO empty, inflight 0, ins_valid_o 0, ins_o 48'h0, ins_addr_o 16'h0, busy_o 0.
REQ-031 Reset mid-RUN SHALL discard FIFO contents and in-flight fetch; reset has priority over all inputs.
REQ-032 After reset release, no issue until start.

Verification
REQ-033 Memory model words = address-tagged; start, start_addr=16'h0010, ins_ready_i=1 -> ins_addr_o 0010,0011,0012,... one per cycle, first valid 2 cycles after start.
REQ-034 ins_ready_i=0 for 10 cycles mid-stream -> FIFO holds 2, mpu_addr frozen, ins_o stable; release -> sequence continues with no gap or duplicate.
REQ-035 jmp to 16'h0100 while FIFO full and fetch in flight -> no pre-jump instruction emitted after jmp; next ins_addr_o = 0100.
REQ-036 start_addr=16'hFFFE -> ins_addr_o FFFE, FFFF, 0000, 0001.
REQ-037 stop during backpressure, then start 16'h0020 -> ins_valid_o low after stop, first output 0020.
REQ-038 sys_rst_n low for 1 cycle mid-RUN -> all outputs at reset values next cycle; no output until start.
